// File: rtl/vec_pingpong_buffer.sv
// Double-banked vector buffer: a producer fills one bank while a consumer reads the other.
// Banks change hands through done strobes, and rejected accesses raise one-cycle flags.
module vec_pingpong_buffer #(
    parameter int unsigned ELEM_WIDTH = 8,
    parameter int unsigned NUM_ELEM   = 48,
    parameter int unsigned ARR_DEPTH  = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(ARR_DEPTH),
    parameter int unsigned VEC_WIDTH  = ELEM_WIDTH * NUM_ELEM
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr_wr,
    input  logic [VEC_WIDTH-1:0]  i_data_wr,
    input  logic [NUM_ELEM-1:0]   i_mask_wr,
    input  logic                  i_wr_done,
    output logic                  o_wr_ready,
    output logic                  o_wr_bank,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr_rd,
    output logic [VEC_WIDTH-1:0]  o_data_rd,
    output logic                  o_rd_valid,
    input  logic                  i_rd_done,
    output logic                  o_rd_ready,
    output logic                  o_rd_bank,
    output logic                  o_ovf,
    output logic                  o_udf
);

    logic [VEC_WIDTH-1:0] mem_q [2][ARR_DEPTH];
    logic [1:0]           full_q, full_d;
    logic                 wr_sel_q, wr_sel_d;
    logic                 rd_sel_q, rd_sel_d;
    logic [VEC_WIDTH-1:0] data_rd_q;
    logic                 rd_valid_q, ovf_q, udf_q;

    logic                 wr_ready, rd_ready;
    logic                 wr_acc, rd_acc, wr_swap, rd_swap;
    logic                 wr_in_range, rd_in_range;
    logic [VEC_WIDTH-1:0] wr_vec, rd_vec;

    assign wr_ready    = !full_q[wr_sel_q];
    assign rd_ready    = full_q[rd_sel_q];
    assign wr_acc      = i_we && wr_ready;
    assign rd_acc      = i_re && rd_ready;
    assign wr_swap     = i_wr_done && wr_ready;
    assign rd_swap     = i_rd_done && rd_ready;
    assign wr_in_range = int'(i_addr_wr) < int'(ARR_DEPTH);
    assign rd_in_range = int'(i_addr_rd) < int'(ARR_DEPTH);

    // Read-modify-write merge so unmasked elements keep their stored value.
    always_comb begin
        wr_vec = '0;
        if (wr_in_range) begin
            wr_vec = mem_q[wr_sel_q][i_addr_wr];
        end
        for (int e = 0; e < int'(NUM_ELEM); e++) begin
            if (i_mask_wr[e]) begin
                wr_vec[e*ELEM_WIDTH +: ELEM_WIDTH] = i_data_wr[e*ELEM_WIDTH +: ELEM_WIDTH];
            end
        end
    end

    always_comb begin
        rd_vec = '0;
        if (rd_in_range) begin
            rd_vec = mem_q[rd_sel_q][i_addr_rd];
        end
    end

    // A bank can only be filled when free and released when full, so the two updates
    // below never target the same bank in one cycle.
    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        if (wr_swap) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end
        if (rd_swap) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full_q     <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            data_rd_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            rd_valid_q <= rd_acc;
            ovf_q      <= (i_we || i_wr_done) && !wr_ready;
            udf_q      <= (i_re || i_rd_done) && !rd_ready;
            if (rd_acc) begin
                data_rd_q <= rd_vec;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < int'(ARR_DEPTH); a++) begin
                    mem_q[b][a] <= '0;
                end
            end
        end else if (wr_acc && wr_in_range) begin
            mem_q[wr_sel_q][i_addr_wr] <= wr_vec;
        end
    end

    assign o_wr_ready = wr_ready;
    assign o_rd_ready = rd_ready;
    assign o_wr_bank  = wr_sel_q;
    assign o_rd_bank  = rd_sel_q;
    assign o_data_rd  = data_rd_q;
    assign o_rd_valid = rd_valid_q;
    assign o_ovf      = ovf_q;
    assign o_udf      = udf_q;

endmodule

// File: doc/vec_pingpong_buffer.md
# vec_pingpong_buffer

Double-banked (ping-pong) vector buffer with per-element write masks and a bank-swap handshake, successor to the single-bank register-array buffer. A producer (e.g. a matmul output stage) fills one bank while a consumer (e.g. softmax/layernorm stage) reads the other; banks hand over via done strobes. Read port is registered, and illegal accesses are flagged rather than silently dropped.

## Interface
- ELEM_WIDTH, 8, bits per vector element
- NUM_ELEM, 48, elements per vector (VEC_WIDTH = ELEM_WIDTH*NUM_ELEM = 384)
- ARR_DEPTH, 16, vectors per bank
- ADDR_WIDTH, $clog2(ARR_DEPTH), entry address width
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_we  in  1  write strobe into current write bank
- i_addr_wr  in  ADDR_WIDTH  write entry address
- i_data_wr  in  VEC_WIDTH  write data, element e = bits [e*ELEM_WIDTH +: ELEM_WIDTH]
- i_mask_wr  in  NUM_ELEM  per-element write enable
- i_wr_done  in  1  producer finished current write bank
- o_wr_ready  out  1  current write bank is free
- o_wr_bank  out  1  index of current write bank
- i_re  in  1  read strobe from current read bank
- i_addr_rd  in  ADDR_WIDTH  read entry address
- o_data_rd  out  VEC_WIDTH  registered read data
- o_rd_valid  out  1  o_data_rd valid this cycle
- i_rd_done  in  1  consumer releases current read bank
- o_rd_ready  out  1  current read bank holds data
- o_rd_bank  out  1  index of current read bank
- o_ovf  out  1  one-cycle pulse: write-side access rejected
- o_udf  out  1  one-cycle pulse: read-side access rejected

## Operation
- State: mem[2][ARR_DEPTH], full[1:0], wr_sel, rd_sel.
- o_wr_ready = !full[wr_sel]; o_rd_ready = full[rd_sel]; o_wr_bank = wr_sel; o_rd_bank = rd_sel (all from registers, no input-to-output combinational path).
- Write accepted iff i_we && o_wr_ready: for each e with i_mask_wr[e]=1, mem[wr_sel][i_addr_wr].elem[e] <= i_data_wr elem e; unmasked elements keep old value. All-zero mask = accepted no-op.
- i_wr_done && o_wr_ready: full[wr_sel] <= 1, wr_sel <= ~wr_sel. A write in the same cycle lands in the old bank.
- Read accepted iff i_re && o_rd_ready: o_data_rd <= mem[rd_sel][i_addr_rd], o_rd_valid <= 1; else o_rd_valid <= 0, o_data_rd holds.
- i_rd_done && o_rd_ready: full[rd_sel] <= 0, rd_sel <= ~rd_sel. A read in the same cycle is served from the old bank.
- wr_done and rd_done in the same cycle act on different banks (full vs. free) and both take effect.
- Bank contents are not cleared on release; stale data is overwritten only by masked writes.
- o_ovf <= (i_we || i_wr_done) && !o_wr_ready; o_udf <= (i_re || i_rd_done) && !o_rd_ready. Rejected operations change no state.
- Per-bank sequence: FREE -> (wr_done) -> FULL -> (rd_done) -> FREE. Two banks give at most 2 full banks, at which point o_wr_ready=0.
- Address ≥ ARR_DEPTH (non-power-of-2 depth): write ignored, read returns 0; no flag.

## Timing
- Reset (async assert, sync release): all mem = 0, full = 2'b00, wr_sel = 0, rd_sel = 0, o_data_rd = 0, o_rd_valid = 0, o_ovf = 0, o_udf = 0; hence o_wr_ready = 1, o_rd_ready = 0.
- Reset mid-operation discards all banks and in-flight reads; o_rd_valid drops immediately.
- Write latency: data visible to a read issued the cycle after the write edge.
- Read latency: 1 cycle (i_re at edge N -> o_rd_valid/o_data_rd after edge N+1... i.e. valid in cycle N+1).
- wr_done at edge N -> o_rd_ready=1 in cycle N+1 (when that bank is the read bank); rd_done at edge N -> o_wr_ready=1 in cycle N+1.
- o_ovf/o_udf assert in the cycle after the offending request, for exactly one cycle per request.

## Test plan
- Reset: after i_rst pulse, o_wr_ready=1, o_rd_ready=0, o_wr_bank=0, o_rd_bank=0, o_rd_valid=0, o_data_rd=0.
- Ping-pong: write addr 0..15 bank 0 with pattern A, wr_done; write bank 1 with B while reading bank 0 -> 16 reads return A, 1-cycle latency; rd_done, then bank 1 reads return B.
- Mask: write all-0xFF to addr 3, then 0x00 vector with mask = 48'h1 -> read gives element 0 = 0x00, elements 1..47 = 0xFF; all-zero mask leaves entry unchanged.
- Backpressure: wr_done twice without rd_done -> o_wr_ready=0; further i_we -> o_ovf pulse, memory unchanged; i_re with full[rd_sel]=0 at start -> o_udf pulse, o_rd_valid=0.
- Simultaneous: bank 0 full, bank 1 filling; same cycle i_we addr 5, i_wr_done, i_re addr 5, i_rd_done -> write lands in bank 1, read returns bank 0 data, both banks swap, full = 2'b10 after edge.
- Reset mid-read: assert i_rst during cycle of o_rd_valid=1 -> o_rd_valid=0 and full=0 immediately, o_data_rd=0.
